// File: rtl/axi_master_pkg.sv
// Shared definitions for the AXI burst master: widths, burst codes, FSM states,
// the registered command and the AXI master/slave signal bundles.
package axi_master_pkg;

  localparam int ID_W_WIDTH = 4;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 32;
  localparam int BYTE_WIDTH = 8;
  localparam int STRB_W     = DATA_WIDTH / BYTE_WIDTH;

  // AxSIZE encodes bytes per beat as log2, so a full-width beat is log2(STRB_W).
  localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    AR,
    R,
    DONE
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [ID_W_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [1:0]            burst;
    logic [DATA_WIDTH-1:0] seed;
  } cmd_t;

  typedef struct packed {
    logic                  aw_valid;
    logic [ID_W_WIDTH-1:0] aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  w_last;
    logic                  b_ready;
    logic                  ar_valid;
    logic [ID_W_WIDTH-1:0] ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  r_ready;
  } axi_mosi_t;

  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic                  b_valid;
    logic [ID_W_WIDTH-1:0] b_id;
    logic                  ar_ready;
    logic                  r_valid;
    logic [ID_W_WIDTH-1:0] r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
  } axi_miso_t;

  // Beat payload: the seed advanced by the beat index, wrapping at the data width.
  function automatic logic [DATA_WIDTH-1:0] pattern_word(input logic [DATA_WIDTH-1:0] seed,
                                                         input logic [7:0]            beat);
    return seed + DATA_WIDTH'(beat);
  endfunction

endpackage

// File: rtl/axi_pattern_gen.sv
// Pattern source for write beats and checker for read beats; keeps a saturating
// mismatch count that is cleared when a new command is accepted.
module axi_pattern_gen
  import axi_master_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic [7:0]            beat_i,
  input  logic                  clear_i,
  input  logic                  check_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] pattern_o,
  output logic [7:0]            err_cnt_o
);

  logic [7:0] err_cnt_q;
  logic       mismatch;

  assign pattern_o = pattern_word(seed_i, beat_i);
  assign mismatch  = check_i && (data_i != pattern_o);
  assign err_cnt_o = err_cnt_q;

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_q <= 8'd0;
    end else if (clear_i) begin
      err_cnt_q <= 8'd0;
    end else if (mismatch && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/axi_burst_master.sv
// Command-driven AXI4 burst master: issues one write (AW/W/B) or read (AR/R) burst
// per command, generates or checks a seed pattern, and reports a completion status.
module axi_burst_master
  import axi_master_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ID_W_WIDTH-1:0] cmd_id_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]            cmd_len_i,
  input  logic [1:0]            cmd_burst_i,
  input  logic [DATA_WIDTH-1:0] cmd_seed_i,
  output logic                  done_o,
  output logic                  done_err_o,
  output logic [7:0]            err_cnt_o,
  output axi_mosi_t             out_mosi_o,
  input  axi_miso_t             out_miso_i
);

  state_e                state_q;
  state_e                state_d;
  cmd_t                  cmd_q;
  logic [7:0]            beat_q;
  logic                  err_flag_q;

  logic                  accept;
  logic                  last_beat;
  logic                  w_fire;
  logic                  b_fire;
  logic                  r_beat;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] pattern;

  assign accept    = (state_q == IDLE) && cmd_valid_i;
  assign last_beat = (beat_q == cmd_q.len);
  assign w_fire    = (state_q == W) && out_miso_i.w_ready;
  assign b_fire    = (state_q == B) && out_miso_i.b_valid;
  assign r_beat    = (state_q == R) && out_miso_i.r_valid;
  assign r_err     = (out_miso_i.r_id != cmd_q.id) || (out_miso_i.r_last != last_beat);

  axi_pattern_gen u_pattern (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .seed_i    (cmd_q.seed),
    .beat_i    (beat_q),
    .clear_i   (accept),
    .check_i   (r_beat && !cmd_q.write),
    .data_i    (out_miso_i.r_data),
    .pattern_o (pattern),
    .err_cnt_o (err_cnt_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the default assignment at the top keeps this combinational block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid_i) state_d = cmd_write_i ? AW : AR;
      AW:   if (out_miso_i.aw_ready) state_d = W;
      W:    if (w_fire && last_beat) state_d = B;
      B:    if (b_fire) state_d = DONE;
      AR:   if (out_miso_i.ar_ready) state_d = R;
      R:    if (r_beat && last_beat) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command, beat counter and sticky error flag; the beat with beat == len always
  // ends a burst, so an early RLAST only raises the flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_q      <= '0;
      beat_q     <= 8'd0;
      err_flag_q <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q <= '{write: cmd_write_i, id: cmd_id_i, addr: cmd_addr_i,
                   len: cmd_len_i, burst: cmd_burst_i, seed: cmd_seed_i};
        beat_q     <= 8'd0;
        err_flag_q <= 1'b0;
      end
      if (w_fire || r_beat) begin
        beat_q <= beat_q + 8'd1;
      end
      if (b_fire && (out_miso_i.b_id != cmd_q.id)) begin
        err_flag_q <= 1'b1;
      end
      if (r_beat && r_err) begin
        err_flag_q <= 1'b1;
      end
    end
  end

  // Payload fields follow the registered command, which only changes in IDLE,
  // so they are stable for as long as any valid is held.
  always_comb begin
    out_mosi_o          = '0;
    out_mosi_o.aw_id    = cmd_q.id;
    out_mosi_o.aw_addr  = cmd_q.addr;
    out_mosi_o.aw_len   = cmd_q.len;
    out_mosi_o.aw_size  = AXI_SIZE;
    out_mosi_o.aw_burst = cmd_q.burst;
    out_mosi_o.w_data   = pattern;
    out_mosi_o.w_strb   = '1;
    out_mosi_o.w_last   = last_beat;
    out_mosi_o.ar_id    = cmd_q.id;
    out_mosi_o.ar_addr  = cmd_q.addr;
    out_mosi_o.ar_len   = cmd_q.len;
    out_mosi_o.ar_size  = AXI_SIZE;
    out_mosi_o.ar_burst = cmd_q.burst;
    unique case (state_q)
      AW:      out_mosi_o.aw_valid = 1'b1;
      W:       out_mosi_o.w_valid  = 1'b1;
      B:       out_mosi_o.b_ready  = 1'b1;
      AR:      out_mosi_o.ar_valid = 1'b1;
      R:       out_mosi_o.r_ready  = 1'b1;
      default: ;
    endcase
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign done_o      = (state_q == DONE);
  assign done_err_o  = err_flag_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench: burst master driving a behavioural AXI-to-RAM slave over a 16-word RAM,
// with scoreboards for AW/AR payloads, W beats and completion status.
module tb_axi_burst_master;
  import axi_master_pkg::*;

  logic                  clk_i   = 1'b0;
  logic                  rst_n_i = 1'b0;
  logic                  cmd_valid_i = 1'b0;
  logic                  cmd_ready_o;
  logic                  cmd_write_i = 1'b0;
  logic [ID_W_WIDTH-1:0] cmd_id_i    = '0;
  logic [ADDR_WIDTH-1:0] cmd_addr_i  = '0;
  logic [7:0]            cmd_len_i   = '0;
  logic [1:0]            cmd_burst_i = '0;
  logic [DATA_WIDTH-1:0] cmd_seed_i  = '0;
  logic                  done_o;
  logic                  done_err_o;
  logic [7:0]            err_cnt_o;
  axi_mosi_t             mosi;
  axi_miso_t             miso;

  always #5 clk_i = ~clk_i;

  axi_burst_master dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write_i),
    .cmd_id_i    (cmd_id_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_burst_i (cmd_burst_i),
    .cmd_seed_i  (cmd_seed_i),
    .done_o      (done_o),
    .done_err_o  (done_err_o),
    .err_cnt_o   (err_cnt_o),
    .out_mosi_o  (mosi),
    .out_miso_i  (miso)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [ID_W_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ax_exp_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } w_exp_t;

  typedef struct packed {
    logic       err;
    logic [7:0] cnt;
  } done_exp_t;

  ax_exp_t               aw_q[$];
  ax_exp_t               ar_q[$];
  w_exp_t                w_q[$];
  done_exp_t             done_q[$];
  logic [ADDR_WIDTH-1:0] rd_addr_log[$];

  // ---------------- slave model: AXI-to-RAM bridge over a 16-word RAM ----------------
  logic [DATA_WIDTH-1:0] ram [16];
  logic                  stall_en = 1'b0;
  logic                  w_active, b_pend, r_active;
  logic [ID_W_WIDTH-1:0] wid, rid;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [7:0]            wlen, rlen, wbeat, rbeat;
  logic [1:0]            wburst, rburst;

  function automatic logic go();
    return !stall_en || ($urandom_range(0, 1) == 0);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0]            burst);
    return (burst == BURST_FIXED) ? a : a + ADDR_WIDTH'(1);
  endfunction

  task automatic slave_reset();
    w_active = 1'b0; b_pend = 1'b0; r_active = 1'b0;
    wid = '0; rid = '0; waddr = '0; raddr = '0;
    wlen = '0; rlen = '0; wbeat = '0; rbeat = '0; wburst = '0; rburst = '0;
    miso = '0;
  endtask

  task automatic slave_drive();
    miso.aw_ready = !w_active && !b_pend && go();
    miso.w_ready  = w_active && go();
    miso.b_valid  = b_pend;
    miso.b_id     = wid;
    miso.ar_ready = !r_active && go();
    miso.r_valid  = r_active && go();
    miso.r_id     = rid;
    miso.r_data   = ram[raddr];
    miso.r_last   = (rbeat == rlen);
  endtask

  task automatic ax_check(input string tag, input logic [63:0] obs, inout ax_exp_t q[$]);
    check({tag, "_expected"}, 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) check(tag, obs, q.pop_front());
  endtask

  initial begin : slave
    axi_mosi_t m;
    logic      aw_f, w_f, b_f, ar_f, r_f;
    w_exp_t    e;
    slave_reset();
    forever begin
      @(negedge clk_i);
      m    = mosi;
      aw_f = m.aw_valid && miso.aw_ready;
      w_f  = m.w_valid && miso.w_ready;
      b_f  = miso.b_valid && m.b_ready;
      ar_f = m.ar_valid && miso.ar_ready;
      r_f  = miso.r_valid && m.r_ready;
      @(posedge clk_i);
      #1;
      if (!rst_n_i) begin
        slave_reset();
      end else begin
        if (aw_f) begin
          ax_check("aw_payload", {m.aw_id, m.aw_addr, m.aw_len, m.aw_size, m.aw_burst}, aw_q);
          w_active = 1'b1; wid = m.aw_id; waddr = m.aw_addr;
          wlen = m.aw_len; wburst = m.aw_burst; wbeat = '0;
        end
        if (w_f) begin
          for (int i = 0; i < STRB_W; i++)
            if (m.w_strb[i]) ram[waddr][BYTE_WIDTH*i +: BYTE_WIDTH] = m.w_data[BYTE_WIDTH*i +: BYTE_WIDTH];
          check("w_expected", 64'(w_q.size() != 0), 64'd1);
          if (w_q.size() != 0) begin
            e = w_q.pop_front();
            check("wdata", m.w_data, e.data);
            check("wlast", m.w_last, e.last);
            check("wstrb", m.w_strb, 4'hF);
          end
          waddr = next_addr(waddr, wburst);
          if (wbeat == wlen) begin
            w_active = 1'b0;
            b_pend   = 1'b1;
          end
          wbeat++;
        end
        if (b_f) b_pend = 1'b0;
        if (ar_f) begin
          ax_check("ar_payload", {m.ar_id, m.ar_addr, m.ar_len, m.ar_size, m.ar_burst}, ar_q);
          r_active = 1'b1; rid = m.ar_id; raddr = m.ar_addr;
          rlen = m.ar_len; rburst = m.ar_burst; rbeat = '0;
        end
        if (r_f) begin
          rd_addr_log.push_back(raddr);
          raddr = next_addr(raddr, rburst);
          if (rbeat == rlen) r_active = 1'b0;
          rbeat++;
        end
        slave_drive();
      end
    end
  end

  // ---------------- completion scoreboard ----------------
  initial begin : done_mon
    done_exp_t e;
    forever begin
      @(negedge clk_i);
      if (done_o) begin
        check("done_expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) begin
          e = done_q.pop_front();
          check("done_err", done_err_o, e.err);
          check("err_cnt", err_cnt_o, e.cnt);
        end
      end
    end
  end

  // ---------------- payload stability while VALID & !READY ----------------
  initial begin : stable_mon
    axi_mosi_t p;
    logic      aw_p, w_p, ar_p;
    aw_p = 1'b0; w_p = 1'b0; ar_p = 1'b0; p = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        aw_p = 1'b0; w_p = 1'b0; ar_p = 1'b0;
      end else begin
        if (aw_p) check("aw_stable", {mosi.aw_valid, mosi.aw_id, mosi.aw_addr, mosi.aw_len, mosi.aw_size, mosi.aw_burst},
                                     {1'b1, p.aw_id, p.aw_addr, p.aw_len, p.aw_size, p.aw_burst});
        if (w_p)  check("w_stable", {mosi.w_valid, mosi.w_data, mosi.w_strb, mosi.w_last},
                                    {1'b1, p.w_data, p.w_strb, p.w_last});
        if (ar_p) check("ar_stable", {mosi.ar_valid, mosi.ar_id, mosi.ar_addr, mosi.ar_len, mosi.ar_size, mosi.ar_burst},
                                     {1'b1, p.ar_id, p.ar_addr, p.ar_len, p.ar_size, p.ar_burst});
        aw_p = mosi.aw_valid && !miso.aw_ready;
        w_p  = mosi.w_valid && !miso.w_ready;
        ar_p = mosi.ar_valid && !miso.ar_ready;
        p    = mosi;
      end
    end
  end

  // Drive one command and wait until the DUT takes it.
  task automatic send_cmd(input logic wr, input logic [ID_W_WIDTH-1:0] id, input logic [ADDR_WIDTH-1:0] addr,
                          input logic [7:0] len, input logic [1:0] burst, input logic [DATA_WIDTH-1:0] seed);
    logic accepted;
    if (wr) begin
      aw_q.push_back('{id: id, addr: addr, len: len, size: 3'd2, burst: burst});
      for (int i = 0; i <= int'(len); i++)
        w_q.push_back('{data: seed + DATA_WIDTH'(i), last: (i == int'(len))});
    end else begin
      ar_q.push_back('{id: id, addr: addr, len: len, size: 3'd2, burst: burst});
    end
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_id_i = id;
    cmd_addr_i = addr; cmd_len_i = len; cmd_burst_i = burst; cmd_seed_i = seed;
    accepted = 1'b0;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk_i);
      if (cmd_ready_o) accepted = 1'b1;
    end
    check("cmd_accept", accepted, 1'b1);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  // Full command: expected status goes to the scoreboard; latency is checked on a zero-wait slave.
  task automatic issue(input logic wr, input logic [ID_W_WIDTH-1:0] id, input logic [ADDR_WIDTH-1:0] addr,
                       input logic [7:0] len, input logic [1:0] burst, input logic [DATA_WIDTH-1:0] seed,
                       input logic exp_err, input logic [7:0] exp_cnt);
    logic got;
    int   cycles;
    int   lat_exp;
    done_q.push_back('{err: exp_err, cnt: exp_cnt});
    send_cmd(wr, id, addr, len, burst, seed);
    lat_exp = wr ? int'(len) + 4 : int'(len) + 3;
    got = 1'b0;
    cycles = 0;
    for (int c = 1; c <= 600 && !got; c++) begin
      @(negedge clk_i);
      if (done_o) begin
        got = 1'b1;
        cycles = c;
      end
    end
    check("done_seen", got, 1'b1);
    if (got) begin
      if (!stall_en) check("latency", 64'(cycles), 64'(lat_exp));
      @(negedge clk_i);
      check("done_pulse", done_o, 1'b0);
      check("cnt_hold", err_cnt_o, exp_cnt);
      check("err_hold", done_err_o, exp_err);
    end
  endtask

  initial begin : main
    logic seen;
    for (int i = 0; i < 16; i++) ram[i] = '0;

    repeat (2) @(negedge clk_i);
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_done", {done_o, done_err_o}, 2'b00);
    check("rst_err_cnt", err_cnt_o, 8'd0);
    check("rst_valids", {mosi.aw_valid, mosi.w_valid, mosi.b_ready, mosi.ar_valid, mosi.r_ready}, 5'b0);
    rst_n_i = 1'b1;

    // Directed write then read-back with matching and non-matching seeds.
    issue(1'b1, 4'd3, 4'd2, 8'd3, BURST_INCR, 32'h100, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) check("ram_wr", ram[2+i], 32'h100 + 32'(i));
    issue(1'b0, 4'd5, 4'd2, 8'd3, BURST_INCR, 32'h100, 1'b0, 8'd0);
    issue(1'b0, 4'd5, 4'd2, 8'd3, BURST_INCR, 32'h200, 1'b0, 8'd4);

    // Single-beat write at the top word, then a two-beat read across the address wrap.
    issue(1'b1, 4'd1, 4'd15, 8'd0, BURST_INCR, 32'hDEAD, 1'b0, 8'd0);
    check("ram_15", ram[15], 32'hDEAD);
    rd_addr_log.delete();
    issue(1'b0, 4'd1, 4'd15, 8'd1, BURST_WRAP, 32'hDEAD, 1'b0, 8'd1);
    check("wrap_beats", 64'(rd_addr_log.size()), 64'd2);
    check("wrap_addr0", rd_addr_log[0], 4'd15);
    check("wrap_addr1", rd_addr_log[1], 4'd0);

    // Same traffic with random slave stalls: results must not change.
    stall_en = 1'b1;
    issue(1'b1, 4'd3, 4'd2, 8'd3, BURST_INCR, 32'h100, 1'b0, 8'd0);
    issue(1'b0, 4'd5, 4'd2, 8'd3, BURST_INCR, 32'h100, 1'b0, 8'd0);
    issue(1'b0, 4'd5, 4'd2, 8'd3, BURST_INCR, 32'h200, 1'b0, 8'd4);
    issue(1'b1, 4'd7, 4'd6, 8'd9, BURST_INCR, 32'hABC0, 1'b0, 8'd0);
    issue(1'b0, 4'd7, 4'd6, 8'd9, BURST_INCR, 32'hABC0, 1'b0, 8'd0);
    stall_en = 1'b0;

    // 256-beat bursts over a 16-word RAM: only the last 16 read beats match the
    // final RAM contents; a fully mismatching read saturates the counter.
    issue(1'b1, 4'd9, 4'd0, 8'd255, BURST_INCR, 32'h1000, 1'b0, 8'd0);
    issue(1'b0, 4'd9, 4'd0, 8'd255, BURST_INCR, 32'h1000, 1'b0, 8'd240);
    issue(1'b0, 4'd9, 4'd0, 8'd255, BURST_INCR, 32'h9000, 1'b0, 8'd255);

    // Reset during beat 2 of an 8-beat write.
    send_cmd(1'b1, 4'd2, 4'd8, 8'd7, BURST_INCR, 32'h700);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk_i);
      if (mosi.w_valid && wbeat == 8'd2) seen = 1'b1;
    end
    check("reached_beat2", seen, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    check("midrst_valids", {mosi.aw_valid, mosi.w_valid, mosi.b_ready, mosi.ar_valid, mosi.r_ready}, 5'b0);
    check("midrst_cmd_ready", cmd_ready_o, 1'b1);
    check("midrst_done", done_o, 1'b0);
    aw_q.delete();
    w_q.delete();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    check("no_done_after_rst", seen, 1'b0);

    issue(1'b1, 4'd6, 4'd8, 8'd7, BURST_INCR, 32'h700, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) check("ram_post_rst", ram[8+i], 32'h700 + 32'(i));
    issue(1'b0, 4'd6, 4'd8, 8'd7, BURST_INCR, 32'h700, 1'b0, 8'd0);

    check("scoreboard_empty", 64'(aw_q.size() + ar_q.size() + w_q.size() + done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
